// File: rtl/alu_mc.sv
// alu_mc: multi-cycle handshaked N-bit ALU with iterative shift-add multiplier; define ALU_MC_SIGNED_MUL_EN for signed op 111
module alu_mc #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] y,
    output logic [N-1:0] y_ext,
    output logic [3:0]   flags
);
    localparam int S = $clog2(N);
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
    state_t         state_q;
    logic [2*N-1:0] prod_q, mcand_q, prod_d, prod_f;
    logic [N-1:0]   mplier_q, a_mag, b_mag, y_d, y_q, yx_q;
    logic [S-1:0]   cnt_q, sh;
    logic [N:0]     sum, diff, shl_x, shr_x;
    logic [3:0]     flags_q;
    logic           c_d, v_d;
`ifdef ALU_MC_SIGNED_MUL_EN
    logic           neg_q;
    // multiply magnitudes, restore the sign on the full 2N product
    assign a_mag  = a[N-1] ? -a : a;
    assign b_mag  = b[N-1] ? -b : b;
    assign prod_f = neg_q ? -prod_d : prod_d;
`else
    assign a_mag  = a;
    assign b_mag  = b;
    assign prod_f = prod_d;
`endif
    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign y         = y_q;
    assign y_ext     = yx_q;
    assign flags     = flags_q;
    always_comb begin
        sh     = b[S-1:0];
        sum    = {1'b0, a} + {1'b0, b};
        diff   = {1'b0, a} - {1'b0, b};
        shl_x  = {1'b0, a} << sh;
        shr_x  = {a, 1'b0} >> sh;
        prod_d = prod_q + (mplier_q[0] ? mcand_q : '0);
        y_d    = '0;
        c_d    = 1'b0;
        v_d    = 1'b0;
        case (op)
            3'b000: begin
                y_d = sum[N-1:0];
                c_d = sum[N];
                v_d = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
            end
            3'b001: begin
                y_d = diff[N-1:0];
                c_d = diff[N];
                v_d = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
            end
            3'b010: y_d = a & b;
            3'b011: y_d = a | b;
            3'b100: y_d = ~a;
            3'b101: begin
                y_d = shl_x[N-1:0];
                c_d = shl_x[N];
            end
            3'b110: begin
                y_d = shr_x[N:1];
                c_d = shr_x[0];
            end
            default: y_d = '0;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            y_q      <= '0;
            yx_q     <= '0;
            flags_q  <= '0;
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
`ifdef ALU_MC_SIGNED_MUL_EN
            neg_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    if (op == 3'b111) begin
                        state_q  <= MUL;
                        prod_q   <= '0;
                        mcand_q  <= {{N{1'b0}}, a_mag};
                        mplier_q <= b_mag;
                        cnt_q    <= S'(N - 1);
`ifdef ALU_MC_SIGNED_MUL_EN
                        neg_q    <= a[N-1] ^ b[N-1];
`endif
                    end else begin
                        state_q <= DONE;
                        y_q     <= y_d;
                        yx_q    <= '0;
                        flags_q <= {y_d[N-1], y_d == '0, c_d, v_d};
                    end
                end
                MUL: begin
                    prod_q   <= prod_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q - S'(1);
                    if (cnt_q == '0) begin
                        state_q       <= DONE;
                        {yx_q, y_q}   <= prod_f;
                        flags_q       <= {prod_f[2*N-1], prod_f == '0, 2'b00};
                    end
                end
                DONE: if (out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: scoreboard bench for alu_mc at N=8; honours ALU_MC_SIGNED_MUL_EN for op 111 expectations
module tb_alu_mc;
    typedef struct {
        logic [7:0] y;
        logic [7:0] yx;
        logic [3:0] f;
        int         lat;
    } exp_t;
    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] y;
        logic [7:0] yx;
        logic [3:0] f;
    } vec_t;

    logic       clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    logic       in_ready, out_valid;
    logic [2:0] op = '0;
    logic [7:0] a = '0, b = '0, y, y_ext;
    logic [3:0] flags;
    int         n_checks = 0, n_err = 0;
    exp_t       sb[$];

    alu_mc #(.N(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .y(y), .y_ext(y_ext), .flags(flags)
    );

    always #5 clk = ~clk;

    // flags are {Neg, Zero, Carry, oVerflow}
    vec_t alu_tbl [14] = '{
        '{3'd0, 8'hF0, 8'h20, 8'h10, 8'h00, 4'b0010},
        '{3'd0, 8'h70, 8'h10, 8'h80, 8'h00, 4'b1001},
        '{3'd1, 8'h05, 8'h07, 8'hFE, 8'h00, 4'b1010},
        '{3'd1, 8'h33, 8'h33, 8'h00, 8'h00, 4'b0100},
        '{3'd1, 8'h80, 8'h01, 8'h7F, 8'h00, 4'b0001},
        '{3'd2, 8'hF0, 8'h3C, 8'h30, 8'h00, 4'b0000},
        '{3'd3, 8'h0F, 8'hF0, 8'hFF, 8'h00, 4'b1000},
        '{3'd4, 8'h00, 8'h55, 8'hFF, 8'h00, 4'b1000},
        '{3'd4, 8'hFF, 8'h00, 8'h00, 8'h00, 4'b0100},
        '{3'd5, 8'h81, 8'h01, 8'h02, 8'h00, 4'b0010},
        '{3'd6, 8'h81, 8'h03, 8'h10, 8'h00, 4'b0000},
        '{3'd5, 8'h81, 8'h08, 8'h81, 8'h00, 4'b1000},
        '{3'd6, 8'h01, 8'h01, 8'h00, 8'h00, 4'b0110},
        '{3'd5, 8'h01, 8'h07, 8'h80, 8'h00, 4'b1000}
    };
`ifdef ALU_MC_SIGNED_MUL_EN
    vec_t mul_tbl [6] = '{
        '{3'd7, 8'hFF, 8'hFF, 8'h01, 8'h00, 4'b0000},
        '{3'd7, 8'h00, 8'h37, 8'h00, 8'h00, 4'b0100},
        '{3'd7, 8'h80, 8'h01, 8'h80, 8'hFF, 4'b1000},
        '{3'd7, 8'h0F, 8'h11, 8'hFF, 8'h00, 4'b0000},
        '{3'd7, 8'h80, 8'h80, 8'h00, 8'h40, 4'b0000},
        '{3'd7, 8'hFF, 8'h02, 8'hFE, 8'hFF, 4'b1000}
    };
`else
    vec_t mul_tbl [6] = '{
        '{3'd7, 8'hFF, 8'hFF, 8'h01, 8'hFE, 4'b1000},
        '{3'd7, 8'h00, 8'h37, 8'h00, 8'h00, 4'b0100},
        '{3'd7, 8'h80, 8'h01, 8'h80, 8'h00, 4'b0000},
        '{3'd7, 8'h0F, 8'h11, 8'hFF, 8'h00, 4'b0000},
        '{3'd7, 8'h80, 8'h80, 8'h00, 8'h40, 4'b0000},
        '{3'd7, 8'hFF, 8'h02, 8'hFE, 8'h01, 4'b0000}
    };
`endif

    function automatic exp_t model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
        exp_t       r;
        logic [8:0] t;
        logic [15:0] p;
        logic       c, v;
        int         s, sh;
        r.y = '0; r.yx = '0; r.lat = 1; c = 1'b0; v = 1'b0; sh = int'(z[2:0]);
        case (o)
            3'd0: begin
                t = {1'b0, x} + {1'b0, z}; r.y = t[7:0]; c = t[8];
                s = $signed(x) + $signed(z); v = (s > 127) || (s < -128);
            end
            3'd1: begin
                r.y = x - z; c = x < z;
                s = $signed(x) - $signed(z); v = (s > 127) || (s < -128);
            end
            3'd2: r.y = x & z;
            3'd3: r.y = x | z;
            3'd4: r.y = ~x;
            3'd5: begin r.y = x << sh; c = (sh == 0) ? 1'b0 : x[8-sh]; end
            3'd6: begin r.y = x >> sh; c = (sh == 0) ? 1'b0 : x[sh-1]; end
            default: begin
`ifdef ALU_MC_SIGNED_MUL_EN
                s = $signed(x) * $signed(z); p = 16'(s);
`else
                p = {8'h00, x} * {8'h00, z};
`endif
                {r.yx, r.y} = p; r.lat = 9; r.f = {p[15], p == 16'h0, 2'b00};
                return r;
            end
        endcase
        r.f = {r.y[7], r.y == 8'h00, c, v};
        return r;
    endfunction

    task automatic step;
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
        in_valid = 1'b1; op = o; a = x; b = z;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; out_ready = 1'b1; in_valid = 1'b1; op = 3'd0; a = 8'h11; b = 8'h22;
        repeat (3) step();
        n_checks++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        n_checks++;
        if ({out_valid, y, y_ext, flags} !== 21'h0)
            begin n_err++; $display("FAIL reset_outputs: got v=%b y=%h yx=%h f=%b want all 0", out_valid, y, y_ext, flags); end
        rst = 1'b0; in_valid = 1'b0;
        step();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            begin n_err++; $display("FAIL reset_release: got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid); end
    endtask

    task automatic test_alu_ops;
        exp_t e;
        int   lat;
        logic [2:0] o;
        logic [7:0] x, z;
        out_ready = 1'b1;
        for (int i = 0; i < 38; i++) begin
            if (i < 14) begin
                o = alu_tbl[i].op; x = alu_tbl[i].a; z = alu_tbl[i].b;
                sb.push_back('{alu_tbl[i].y, alu_tbl[i].yx, alu_tbl[i].f, 1});
            end else begin
                o = 3'($urandom_range(0, 6)); x = 8'($urandom); z = 8'($urandom);
                sb.push_back(model(o, x, z));
            end
            send(o, x, z);
            lat = 1;
            while (!out_valid && lat < 20) begin step(); lat++; end
            e = sb.pop_front();
            n_checks++;
            if (lat !== e.lat) begin n_err++; $display("FAIL alu[%0d] latency: got %0d want %0d", i, lat, e.lat); end
            n_checks++;
            if (y !== e.y || y_ext !== e.yx || flags !== e.f)
                begin n_err++; $display("FAIL alu[%0d] op=%0d a=%h b=%h: got y=%h yx=%h f=%b want y=%h yx=%h f=%b",
                                        i, o, x, z, y, y_ext, flags, e.y, e.yx, e.f); end
            step();
        end
    endtask

    task automatic test_mul;
        exp_t e;
        int   lat;
        logic rdy_seen;
        logic [7:0] x, z;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i < 6) begin
                x = mul_tbl[i].a; z = mul_tbl[i].b;
                sb.push_back('{mul_tbl[i].y, mul_tbl[i].yx, mul_tbl[i].f, 9});
            end else begin
                x = 8'($urandom); z = 8'($urandom);
                sb.push_back(model(3'd7, x, z));
            end
            send(3'd7, x, z);
            // a competing request must be ignored while multiplying
            in_valid = 1'b1; op = 3'd0;
            lat = 1; rdy_seen = 1'b0;
            while (!out_valid && lat < 30) begin rdy_seen |= in_ready; step(); lat++; end
            in_valid = 1'b0;
            e = sb.pop_front();
            n_checks++;
            if (lat !== e.lat) begin n_err++; $display("FAIL mul[%0d] latency: got %0d want %0d", i, lat, e.lat); end
            n_checks++;
            if (rdy_seen !== 1'b0) begin n_err++; $display("FAIL mul[%0d] in_ready during MUL: got 1 want 0", i); end
            n_checks++;
            if (y !== e.y || y_ext !== e.yx || flags !== e.f)
                begin n_err++; $display("FAIL mul[%0d] a=%h b=%h: got %h%h f=%b want %h%h f=%b",
                                        i, x, z, y_ext, y, flags, e.yx, e.y, e.f); end
            step();
        end
    endtask

    task automatic test_backpressure;
        exp_t e;
        int   lat;
        out_ready = 1'b0;
        sb.push_back('{8'h46, 8'h00, 4'b0000, 1});
        send(3'd0, 8'h12, 8'h34);
        lat = 1;
        while (!out_valid && lat < 20) begin step(); lat++; end
        e = sb.pop_front();
        in_valid = 1'b1; op = 3'd1; a = 8'h55; b = 8'h11;
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || y !== e.y || y_ext !== e.yx || flags !== e.f)
                begin n_err++; $display("FAIL hold[%0d]: got v=%b rdy=%b y=%h yx=%h f=%b want v=1 rdy=0 y=%h yx=%h f=%b",
                                        k, out_valid, in_ready, y, y_ext, flags, e.y, e.yx, e.f); end
            step();
        end
        out_ready = 1'b1;
        step();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            begin n_err++; $display("FAIL release: got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid); end
        in_valid = 1'b0;
        step();
        n_checks++;
        if (out_valid !== 1'b0 || y !== 8'h46)
            begin n_err++; $display("FAIL held_request: got v=%b y=%h want v=0 y=46", out_valid, y); end
    endtask

    task automatic test_reset_abort;
        int lat;
        out_ready = 1'b1;
        send(3'd7, 8'hFF, 8'hFF);
        repeat (3) step();
        rst = 1'b1;
        step();
        n_checks++;
        if ({out_valid, in_ready, y, y_ext, flags} !== 22'h0)
            begin n_err++; $display("FAIL mid_mul_reset: got v=%b rdy=%b y=%h yx=%h f=%b want all 0",
                                    out_valid, in_ready, y, y_ext, flags); end
        rst = 1'b0; #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_mul_ready: got %b want 1", in_ready); end
        sb.push_back('{8'h02, 8'h00, 4'b0000, 1});
        send(3'd0, 8'h01, 8'h01);
        lat = 1;
        while (!out_valid && lat < 20) begin step(); lat++; end
        n_checks++;
        if (lat !== sb[0].lat || y !== sb[0].y || y_ext !== sb[0].yx || flags !== sb[0].f)
            begin n_err++; $display("FAIL post_reset_add: got lat=%0d y=%h yx=%h f=%b want lat=1 y=02 yx=00 f=0000",
                                    lat, y, y_ext, flags); end
        void'(sb.pop_front());
        step();
        out_ready = 1'b0;
        send(3'd0, 8'h03, 8'h04);
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || y !== 8'h00)
            begin n_err++; $display("FAIL done_reset: got v=%b y=%h want v=0 y=00", out_valid, y); end
        step();
    endtask

    task automatic test_back_to_back;
        exp_t e;
        logic fire;
        int   idx, cyc, last;
        logic [2:0] ops [12];
        logic [7:0] xa [12], xb [12];
        for (int i = 0; i < 12; i++) begin
            ops[i] = 3'($urandom_range(0, 6)); xa[i] = 8'($urandom); xb[i] = 8'($urandom);
        end
        out_ready = 1'b1; fire = 1'b0; idx = 0; cyc = 0; last = -1;
        while ((idx < 12 || sb.size() > 0) && cyc < 200) begin
            step(); cyc++;
            if (fire) idx++;
            in_valid = idx < 12;
            if (idx < 12) begin op = ops[idx]; a = xa[idx]; b = xb[idx]; end
            if (out_valid) begin
                e = sb.pop_front();
                n_checks++;
                if (y !== e.y || y_ext !== e.yx || flags !== e.f)
                    begin n_err++; $display("FAIL b2b cyc %0d: got y=%h yx=%h f=%b want y=%h yx=%h f=%b",
                                            cyc, y, y_ext, flags, e.y, e.yx, e.f); end
            end
            fire = in_valid && in_ready;
            if (fire) begin
                sb.push_back(model(op, a, b));
                if (last >= 0) begin
                    n_checks++;
                    if (cyc - last !== 2) begin n_err++; $display("FAIL b2b gap: got %0d want 2", cyc - last); end
                end
                last = cyc;
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (idx !== 12 || sb.size() !== 0)
            begin n_err++; $display("FAIL b2b drain: got issued=%0d pending=%0d want 12 and 0", idx, sb.size()); end
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_mul();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
